aes_core_arb: RTL
=================

Name: aes_core_arb

Overview:
- Round-robin arbiter and sequencer that shares one AES-128 encrypt core (ld/done handshake, 128-bit key/text_in/text_out) between NREQ requesters inside crypto_trng.
- Accepts one job (key + plaintext) at a time, pulses the core's ld, waits for done, and returns ciphertext tagged with the requester ID.
- A watchdog flags a missing done.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(NREQ)
- TIMEOUT, 16, cycles after ld within which aes_done must arrive (must be > 12)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  grant enable; low blocks new grants, an in-flight job completes
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_key  in  NREQ*128  packed keys, requester i at [128*i +: 128]
- req_text  in  NREQ*128  packed plaintexts, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester that owns the response
- rsp_data  out  128  ciphertext
- rsp_err  out  1  watchdog expired; rsp_data is zero
- busy  out  1  high in any state other than IDLE
- aes_ld  out  1  core load pulse
- aes_key  out  128  core key
- aes_text_in  out  128  core plaintext
- aes_done  in  1  core done pulse
- aes_text_out  in  128  core ciphertext

Behaviour:
Reset values:
- All outputs 0. FSM in IDLE. RR pointer = NREQ-1, so requester 0 has top priority first. Key, text, data and ID registers are 0.

FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If en and any req_valid: req_ready is high combinationally, one-hot, for the winner. The winner is the first requester with req_valid set, searching from pointer+1 upward with wrap.
  - On that cycle, latch the winner's key/text into aes_key/aes_text_in, latch its ID, set the pointer to the winner, and go to LOAD.
  - Otherwise stay in IDLE with req_ready = 0.
- LOAD:
  - aes_ld = 1 for exactly one cycle.
  - Clear the watchdog counter. Go to RUN.
- RUN:
  - aes_ld = 0. The counter increments each cycle.
  - On aes_done = 1: capture aes_text_out into rsp_data, rsp_err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: rsp_data = 0, rsp_err = 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_data and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake go to IDLE. No grant is issued in the same cycle.
  - aes_done pulses seen outside RUN are ignored.

Other rules:
- aes_key and aes_text_in change only on a grant. They stay stable through LOAD, RUN and RESP.
- aes_ld is never asserted outside LOAD. The core is never reloaded mid-operation.
- Nominal timing: aes_done arrives 12 cycles after the aes_ld cycle. Accept-to-rsp_valid latency is 14 cycles.
- Max throughput: one job per 15 cycles with rsp_ready tied high.
- Changing en has no effect on a job that has already been granted.
- req_valid dropping after a grant has no effect.
- A requester may hold req_valid across jobs. Fairness guarantee: any requester with valid held continuously is granted within NREQ grants.
- Asynchronous reset at any point returns to IDLE immediately and drops aes_ld and rsp_valid. The core shares rstn.

Decomposition:
- Package aes_ctrl_pkg holds:
  - state enum {IDLE, LOAD, RUN, RESP}, 2 bits
  - AES_LAT = 12
  - AES_W = 128
- One sub-module, rr_arbiter (NREQ). Inputs: req vector, pointer, enable. Output: one-hot grant plus encoded index. Purely combinational; the pointer register lives in aes_core_arb.

Test Plan:
- FIPS-197 vector: requester 2 sends key 000102…0f, text 00112233…ff, with the core attached.
  - Expect req_ready[2] for one cycle and aes_ld one cycle later.
  - Expect rsp_valid 14 cycles after accept with rsp_id=2, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- Round-robin: all four req_valid held, rsp_ready=1.
  - Grants go 0,1,2,3,0,1 in that order, spaced 15 cycles apart.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid.
  - rsp_* stay stable, busy=1, no req_ready, no aes_ld.
  - After rsp_ready goes high, the next grant comes one cycle after the handshake.
- Watchdog: stub core that never pulses done.
  - Expect rsp_valid after TIMEOUT=16 RUN cycles with rsp_err=1 and rsp_data=0.
  - A late done arriving in RESP is ignored.
- en low with requests pending: no grant.
  - Drop en during RUN: the job completes.
  - Raise en: the grant resumes from pointer+1.
- Reset mid-RUN: rstn low for 2 cycles, then high.
  - All outputs 0 and pointer back to its reset value.
  - The next grant goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES core arbiter/sequencer.
// The state encoding is fixed at 2 bits so the FSM can be probed directly.
package aes_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam int AES_LAT = 12;
   localparam int AES_W   = 128;

endpackage

// File: rtl/aes_core_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
// Grant is one-hot or zero; idx_o is the encoded winner (0 when no grant).
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o
);

   logic           found;
   int             cand;
   logic [IDW-1:0] cand_idx;

   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // Search starts one past the last winner so it gets the lowest priority.
      for (int k = 1; k <= NREQ; k++) begin
         cand     = (int'(ptr_i) + k) % NREQ;
         cand_idx = IDW'(cand);
         if (en_i && !found && req_i[cand_idx]) begin
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_core_arb.sv
// Shares one AES-128 encrypt core between NREQ requesters: grant, load,
// wait for done (with watchdog), then return the tagged ciphertext.
module aes_core_arb
   import aes_ctrl_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*AES_W-1:0] req_key,
   input  logic [NREQ*AES_W-1:0] req_text,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [AES_W-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  aes_ld,
   output logic [AES_W-1:0]      aes_key,
   output logic [AES_W-1:0]      aes_text_in,
   input  logic                  aes_done,
   input  logic [AES_W-1:0]      aes_text_out
);

   localparam int CW = $clog2(TIMEOUT);

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [AES_W-1:0] key_q, key_d;
   logic [AES_W-1:0] text_q, text_d;
   logic [AES_W-1:0] data_q, data_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   win_idx;
   logic             arb_en;
   logic [AES_W-1:0] sel_key, sel_text;

   // Gating with rstn keeps req_ready low while reset is held.
   assign arb_en = en && rstn && (state_q == IDLE);

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (gnt),
      .idx_o (win_idx)
   );

   always_comb begin
      sel_key  = '0;
      sel_text = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == win_idx) begin
            sel_key  = req_key[i*AES_W +: AES_W];
            sel_text = req_text[i*AES_W +: AES_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      key_d   = key_q;
      text_d  = text_q;
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|gnt) begin
               key_d   = sel_key;
               text_d  = sel_text;
               id_d    = win_idx;
               ptr_d   = win_idx;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            // A done arriving on the timeout cycle still counts as success.
            if (aes_done) begin
               data_d  = aes_text_out;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(NREQ - 1);
         id_q    <= '0;
         key_q   <= '0;
         text_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         key_q   <= key_d;
         text_q  <= text_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready   = gnt;
   assign aes_ld      = (state_q == LOAD);
   assign rsp_valid   = (state_q == RESP);
   assign busy        = (state_q != IDLE);
   assign rsp_id      = id_q;
   assign rsp_data    = data_q;
   assign rsp_err     = err_q;
   assign aes_key     = key_q;
   assign aes_text_in = text_q;

endmodule
